serializador_y: RTL and testbench

//  Downstream consumer of the 4-bit code Y (y3..y0) from the 3-bit-to-4-bit decoder stage.

---
 rtl/serial_pkg.sv | 15 +
 rtl/fifo_y.sv | 68 ++++++
 rtl/serializador_y.sv | 169 ++++++++++++++++
 tb/tb_serializador_y.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the code-word serializer.
// Build option: define SERIALIZADOR_PARITY_EN to add an even-parity bit to every frame.
package serial_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_t;

   localparam int unsigned WORD_W          = 4;
   localparam int unsigned FRAME_BITS_BASE = 6;

   // Even parity over one code word (XOR of all bits).
   function automatic logic even_parity(input logic [WORD_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/fifo_y.sv
// Synchronous show-ahead FIFO holding code words between the decoder and the serializer.
// A write while full is dropped even if a read happens on the same edge.
module fifo_y
   import serial_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [WORD_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]     count_q, count_d;
   logic              do_wr, do_rd;

   // Status flags and qualified read/write strobes.
   always_comb begin
      full    = (count_q == FullCnt);
      empty   = (count_q == '0);
      do_wr   = wr_en & ~full;
      do_rd   = rd_en & ~empty;
      rd_data = mem_q[rd_ptr_q];
   end

   // Next-state for pointers and occupancy; pointers wrap at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset since occupancy gates reads.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/serializador_y.sv
// Buffers 4-bit code words and sends each as a UART-style frame:
// start(0), y3..y0 MSB first, optional even parity, stop(1); each bit lasts BIT_TICKS clocks.
// Build option: define SERIALIZADOR_PARITY_EN to insert the parity bit (7-bit frames).
module serializador_y
   import serial_pkg::*;
#(
   parameter int unsigned BIT_TICKS = 4,
   parameter int unsigned DEPTH     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       y3,
   input  logic       y2,
   input  logic       y1,
   input  logic       y0,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx_out,
   output logic       tx_busy,
   output logic [7:0] frame_cnt
);

   localparam int unsigned TickW = $clog2(BIT_TICKS + 1);
   localparam logic [TickW-1:0] TickLast = TickW'(BIT_TICKS - 1);

   tx_state_t         state_q, state_d;
   logic [TickW-1:0]  tick_q, tick_d;
   logic [1:0]        bit_idx_q, bit_idx_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [7:0]        frame_cnt_q, frame_cnt_d;
   logic              tx_out_q, tx_out_d;
   logic              tx_busy_q, tx_busy_d;

   logic              pop;
   logic              bit_end;
   logic              fifo_full, fifo_empty;
   logic [WORD_W-1:0] fifo_rd_data;
   logic [WORD_W-1:0] y_word;

   assign y_word   = {y3, y2, y1, y0};
   assign in_ready = ~fifo_full;

   fifo_y #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (in_valid),
      .wr_data (y_word),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Frame sequencer: next state, bit timing, shift register load and frame counting.
   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      frame_cnt_d = frame_cnt_q;
      pop         = 1'b0;
      bit_end     = (tick_q == TickLast);

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               shreg_d   = fifo_rd_data;
               bit_idx_d = 2'd3;
               tick_d    = '0;
               state_d   = START;
            end
         end
         START: begin
            if (bit_end) begin
               tick_d  = '0;
               state_d = DATA;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               tick_d = '0;
               if (bit_idx_q == 2'd0) begin
`ifdef SERIALIZADOR_PARITY_EN
                  state_d = PAR;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q - 2'd1;
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
`ifdef SERIALIZADOR_PARITY_EN
         PAR: begin
            if (bit_end) begin
               tick_d  = '0;
               state_d = STOP;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               tick_d      = '0;
               frame_cnt_d = frame_cnt_q + 8'd1;
               // Chain straight into the next frame when a word is waiting.
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  shreg_d   = fifo_rd_data;
                  bit_idx_d = 2'd3;
                  state_d   = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level for the state being entered, so tx_out can be registered.
   always_comb begin
      tx_busy_d = (state_d != IDLE);
      case (state_d)
         START:   tx_out_d = 1'b0;
         DATA:    tx_out_d = shreg_d[bit_idx_d];
`ifdef SERIALIZADOR_PARITY_EN
         PAR:     tx_out_d = even_parity(shreg_d);
`endif
         default: tx_out_d = 1'b1;
      endcase
   end

   // State and output registers; reset aborts any frame and idles the line.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         tick_q      <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         frame_cnt_q <= '0;
         tx_out_q    <= 1'b1;
         tx_busy_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         frame_cnt_q <= frame_cnt_d;
         tx_out_q    <= tx_out_d;
         tx_busy_q   <= tx_busy_d;
      end
   end

   assign tx_out    = tx_out_q;
   assign tx_busy   = tx_busy_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_serializador_y.sv
// Bench for serializador_y (BIT_TICKS=2, DEPTH=4). A UART-style receiver model decodes
// the line and is checked against a queue of accepted words and a frame counter model.
module tb_serializador_y;

   localparam int unsigned BT    = 2;
   localparam int unsigned DEPTH = 4;
`ifdef SERIALIZADOR_PARITY_EN
   localparam int FB = 7;
`else
   localparam int FB = 6;
`endif
   localparam int FL = FB * BT;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       y3 = 1'b0, y2 = 1'b0, y1 = 1'b0, y0 = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready, tx_out, tx_busy;
   logic [7:0] frame_cnt;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   logic [7:0] model_cnt = 8'd0;

   serializador_y #(
      .BIT_TICKS (BT),
      .DEPTH     (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .y3        (y3),
      .y2        (y2),
      .y1        (y1),
      .y0        (y0),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .tx_out    (tx_out),
      .tx_busy   (tx_busy),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a word with in_valid held until taken; acc is the accepting edge number.
   task automatic push_word(input logic [3:0] w, output int acc, output bit ok);
      int waited;
      waited = 0;
      {y3, y2, y1, y0} = w;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && waited < 400) begin
         step();
         waited++;
      end
      if (in_ready === 1'b1) begin
         step();
         ok  = 1'b1;
         acc = cyc;
      end else begin
         ok  = 1'b0;
         acc = -1;
      end
      in_valid = 1'b0;
   endtask

   // Receiver model: wait for a start bit, then sample FB bits of BT cycles each.
   task automatic rx_frame(output logic [3:0] w, output bit ok, output int gap);
      logic bitv [FB];
      logic v;
      gap = 0;
      ok  = 1'b1;
      w   = 4'bxxxx;
      while (tx_out !== 1'b0 && gap < 400) begin
         step();
         gap++;
      end
      if (tx_out !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      for (int b = 0; b < FB; b++) begin
         for (int t = 0; t < int'(BT); t++) begin
            v = tx_out;
            if (t == 0) bitv[b] = v;
            else if (v !== bitv[b]) ok = 1'b0;
            if (tx_busy !== 1'b1) ok = 1'b0;
            step();
         end
      end
      w = {bitv[1], bitv[2], bitv[3], bitv[4]};
      if (bitv[0] !== 1'b0 || bitv[FB-1] !== 1'b1) ok = 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
      if (bitv[5] !== ^w) ok = 1'b0;
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      n_tests++;
      if (tx_out !== 1'b1 || tx_busy !== 1'b0 || frame_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_state: tx_out=%b tx_busy=%b frame_cnt=%0d, want 1 0 0",
                  tx_out, tx_busy, frame_cnt);
      end
      rst = 1'b0;
      model_cnt = 8'd0;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: in_ready=%b, want 1", in_ready);
      end
      repeat (3) step();
      n_tests++;
      if (tx_out !== 1'b1 || tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: tx_out=%b tx_busy=%b, want 1 0", tx_out, tx_busy);
      end
   endtask

   // Exact waveform check of one isolated frame, starting one edge after acceptance.
   task automatic test_single(input logic [3:0] w);
      logic exp_bits [FB];
      int   acc;
      bit   ok;
      exp_bits[0] = 1'b0;
      for (int i = 0; i < 4; i++) exp_bits[1+i] = w[3-i];
`ifdef SERIALIZADOR_PARITY_EN
      exp_bits[5] = ^w;
`endif
      exp_bits[FB-1] = 1'b1;
      push_word(w, acc, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL single_push: word %b not accepted", w);
         return;
      end
      n_tests++;
      if (tx_out !== 1'b1 || tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_no_bypass: tx_out=%b tx_busy=%b at accept edge, want 1 0",
                  tx_out, tx_busy);
      end
      for (int c = 0; c < FL; c++) begin
         step();
         n_tests++;
         if (tx_out !== exp_bits[c/BT] || tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_wave word=%b cycle %0d: tx_out=%b tx_busy=%b, want %b 1",
                     w, c, tx_out, tx_busy, exp_bits[c/BT]);
         end
      end
      step();
      model_cnt = model_cnt + 8'd1;
      n_tests++;
      if (tx_out !== 1'b1 || tx_busy !== 1'b0 || frame_cnt !== model_cnt) begin
         n_fail++;
         $display("FAIL single_end word=%b: tx_out=%b tx_busy=%b frame_cnt=%0d, want 1 0 %0d",
                  w, tx_out, tx_busy, frame_cnt, model_cnt);
      end
   endtask

   // Reset while a frame is on the line and more words are queued.
   task automatic test_mid_reset();
      int acc;
      bit ok;
      int bad;
      for (int i = 0; i < 4; i++) push_word(4'($urandom_range(0, 15)), acc, ok);
      repeat (3) step();
      n_tests++;
      if (tx_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset_busy: tx_busy=%b before reset, want 1", tx_busy);
      end
      rst = 1'b1;
      step();
      n_tests++;
      if (tx_out !== 1'b1 || tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_abort: tx_out=%b tx_busy=%b, want 1 0", tx_out, tx_busy);
      end
      repeat (2) step();
      rst = 1'b0;
      model_cnt = 8'd0;
      n_tests++;
      if (frame_cnt !== 8'd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset_release: frame_cnt=%0d in_ready=%b, want 0 1",
                  frame_cnt, in_ready);
      end
      bad = 0;
      for (int c = 0; c < 3 * FL; c++) begin
         step();
         if (tx_out !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL mid_reset_fifo_flushed: %0d non-idle cycles after reset, want 0", bad);
      end
   endtask

   // Push n words with in_valid held; receive and check order, gaps and counter.
   task automatic run_burst(input logic [3:0] words [$], input bit check_stall);
      int acc_cyc [$];
      int n;
      n = words.size();
      fork
         begin
            int acc;
            bit ok;
            for (int i = 0; i < n; i++) begin
               push_word(words[i], acc, ok);
               acc_cyc.push_back(acc);
               n_tests++;
               if (!ok) begin
                  n_fail++;
                  $display("FAIL burst_push %0d: word %b not accepted", i, words[i]);
               end
            end
         end
         begin
            logic [3:0] w;
            bit         ok;
            int         gap;
            for (int i = 0; i < n; i++) begin
               rx_frame(w, ok, gap);
               model_cnt = model_cnt + 8'd1;
               n_tests++;
               if (!ok || w !== words[i] || (i > 0 && gap != 0)) begin
                  n_fail++;
                  $display("FAIL burst_frame %0d: word=%b ok=%0d gap=%0d, want %b 1 0",
                           i, w, ok, gap, words[i]);
               end
               n_tests++;
               if (frame_cnt !== model_cnt) begin
                  n_fail++;
                  $display("FAIL burst_frame_cnt %0d: frame_cnt=%0d, want %0d",
                           i, frame_cnt, model_cnt);
               end
            end
         end
      join
      // FIFO of DEPTH words plus one popped: word DEPTH+1 waits for the second pop.
      if (check_stall && n > int'(DEPTH) + 2) begin
         n_tests++;
         if (acc_cyc[DEPTH+1] - acc_cyc[0] != FL + 2) begin
            n_fail++;
            $display("FAIL full_stall: word %0d accepted %0d cycles after first, want %0d",
                     DEPTH + 1, acc_cyc[DEPTH+1] - acc_cyc[0], FL + 2);
         end
         n_tests++;
         if (acc_cyc[DEPTH+2] - acc_cyc[0] != 2 * FL + 2) begin
            n_fail++;
            $display("FAIL full_stall2: word %0d accepted %0d cycles after first, want %0d",
                     DEPTH + 2, acc_cyc[DEPTH+2] - acc_cyc[0], 2 * FL + 2);
         end
      end
      step();
      n_tests++;
      if (tx_out !== 1'b1 || tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL burst_idle: tx_out=%b tx_busy=%b, want 1 0", tx_out, tx_busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] words [$];
      words = '{4'b0101, 4'b0011, 4'b0001, 4'b0111, 4'b1001};
      run_burst(words, 1'b0);
   endtask

   task automatic test_full();
      logic [3:0] words [$];
      for (int i = 0; i < 7; i++) words.push_back(4'($urandom_range(0, 15)));
      run_burst(words, 1'b1);
   endtask

   // Random words with random spacing, checked through a scoreboard queue.
   task automatic test_random();
      logic [3:0] sb [$];
      int         n;
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(1, 8);
         fork
            begin
               int         acc;
               bit         ok;
               logic [3:0] w;
               for (int i = 0; i < n; i++) begin
                  repeat ($urandom_range(0, 20)) step();
                  w = 4'($urandom_range(0, 15));
                  push_word(w, acc, ok);
                  if (ok) sb.push_back(w);
               end
            end
            begin
               logic [3:0] w;
               logic [3:0] exp_w;
               bit         ok;
               int         gap;
               for (int i = 0; i < n; i++) begin
                  rx_frame(w, ok, gap);
                  model_cnt = model_cnt + 8'd1;
                  exp_w = (sb.size() > 0) ? sb.pop_front() : 4'bxxxx;
                  n_tests++;
                  if (!ok || w !== exp_w) begin
                     n_fail++;
                     $display("FAIL random_frame r%0d/%0d: word=%b ok=%0d, want %b",
                              r, i, w, ok, exp_w);
                  end
               end
            end
         join
         step();
         n_tests++;
         if (frame_cnt !== model_cnt || tx_out !== 1'b1) begin
            n_fail++;
            $display("FAIL random_end r%0d: frame_cnt=%0d tx_out=%b, want %0d 1",
                     r, frame_cnt, tx_out, model_cnt);
         end
      end
   endtask

   // 256 frames in bursts of 16: the counter passes 255 -> 0; line idles between bursts.
   task automatic test_wrap();
      logic [3:0] words [$];
      int         bad;
      for (int b = 0; b < 16; b++) begin
         words.delete();
         for (int i = 0; i < 16; i++) words.push_back(4'($urandom_range(0, 15)));
         run_burst(words, 1'b0);
         bad = 0;
         for (int c = 0; c < 4; c++) begin
            step();
            if (tx_out !== 1'b1 || tx_busy !== 1'b0) bad++;
         end
         n_tests++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL wrap_idle burst %0d: %0d non-idle cycles, want 0", b, bad);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single(4'b0101);
      test_single(4'b1001);
      test_single(4'($urandom_range(0, 15)));
      test_single(4'($urandom_range(0, 15)));
      test_mid_reset();
      test_back_to_back();
      test_full();
      test_random();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
